// File: rtl/csr_register_file_if.sv
// Decoder-to-CSR-unit bus for csr_register_file: CSR control, trap/mret events and redirect outputs.
interface csr_register_file_if;
    logic        CSR_reg_rd;
    logic        CSR_reg_wr;
    logic [1:0]  CSR_wd_select;
    logic        RD1_RS1_sel;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  uimm;
    logic        instr_retired;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    modport master (
        output CSR_reg_rd, CSR_reg_wr, CSR_wd_select, RD1_RS1_sel, csr_addr, rs1_data, uimm,
               instr_retired, trap_valid, trap_cause, trap_pc, mret,
        input  csr_rdata, illegal_csr, mtvec_out, mepc_out, mie_out
    );

    modport slave (
        input  CSR_reg_rd, CSR_reg_wr, CSR_wd_select, RD1_RS1_sel, csr_addr, rs1_data, uimm,
               instr_retired, trap_valid, trap_cause, trap_pc, mret,
        output csr_rdata, illegal_csr, mtvec_out, mepc_out, mie_out
    );
endinterface

// File: rtl/csr_register_file.sv
// Machine-mode CSR storage/update unit with trap entry and mret redirect targets.
// The 64-bit mcycle/minstret counters and their CSR addresses exist only when CSR_COUNTERS_EN is defined.
module csr_register_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    csr_register_file_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    logic        mie_r;
    logic        mpie_r;
    logic [29:0] mtvec_r;
    logic [29:0] mepc_r;
    logic [31:0] mscratch_r;
    logic [31:0] mcause_r;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_r;
    logic [63:0] minstret_r;
`endif
    logic [31:0] cur_s;
    logic [31:0] src_s;
    logic [31:0] new_s;
    logic        impl_s;
    logic        illegal_s;
    logic        we_s;
    logic        unused_s;

    // Address decode: current value of the addressed CSR and whether it exists
    always_comb begin
        cur_s  = 32'h0000_0000;
        impl_s = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS:  cur_s = {24'h00_0000, mpie_r, 3'b000, mie_r, 3'b000};
            ADDR_MTVEC:    cur_s = {mtvec_r, 2'b00};
            ADDR_MSCRATCH: cur_s = mscratch_r;
            ADDR_MEPC:     cur_s = {mepc_r, 2'b00};
            ADDR_MCAUSE:   cur_s = mcause_r;
            ADDR_MHARTID:  cur_s = HART_ID;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE,   ADDR_CYCLE:    cur_s = mcycle_r[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   cur_s = mcycle_r[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  cur_s = minstret_r[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: cur_s = minstret_r[63:32];
`endif
            default:       impl_s = 1'b0;
        endcase
    end

    // Write-data formation for csrrw/csrrs/csrrc and their immediate forms
    always_comb begin
        src_s = bus.RD1_RS1_sel ? {27'h000_0000, bus.uimm} : bus.rs1_data;
        case (bus.CSR_wd_select)
            2'b00:   new_s = src_s;
            2'b01:   new_s = cur_s | src_s;
            2'b10:   new_s = cur_s & ~src_s;
            default: new_s = cur_s;
        endcase
    end

    // The 0xC00-0xFFF block is read-only, so writes there are illegal even when implemented
    assign illegal_s = (bus.CSR_reg_rd | bus.CSR_reg_wr)
                     & (~impl_s | (bus.CSR_reg_wr & (bus.csr_addr[11:10] == 2'b11)));
    assign we_s      = bus.CSR_reg_wr & ~illegal_s & ~bus.trap_valid;
    assign unused_s  = ^{bus.instr_retired, bus.trap_pc[1:0]};

    assign bus.csr_rdata   = bus.CSR_reg_rd ? cur_s : 32'h0000_0000;
    assign bus.illegal_csr = illegal_s;
    assign bus.mtvec_out   = {mtvec_r, 2'b00};
    assign bus.mepc_out    = {mepc_r, 2'b00};
    assign bus.mie_out     = mie_r;

    // Trap state and CSR writes: trap beats mret, mret beats a write to mstatus
    always_ff @(posedge clk) begin
        if (!rst) begin
            mie_r      <= 1'b0;
            mpie_r     <= 1'b0;
            mtvec_r    <= MTVEC_RESET[31:2];
            mepc_r     <= 30'h0000_0000;
            mscratch_r <= 32'h0000_0000;
            mcause_r   <= 32'h0000_0000;
        end else if (bus.trap_valid) begin
            mepc_r   <= bus.trap_pc[31:2];
            mcause_r <= bus.trap_cause;
            mpie_r   <= mie_r;
            mie_r    <= 1'b0;
        end else begin
            if (bus.mret) begin
                mie_r  <= mpie_r;
                mpie_r <= 1'b1;
            end else if (we_s && (bus.csr_addr == ADDR_MSTATUS)) begin
                mie_r  <= new_s[3];
                mpie_r <= new_s[7];
            end
            if (we_s) begin
                case (bus.csr_addr)
                    ADDR_MTVEC:    mtvec_r    <= new_s[31:2];
                    ADDR_MSCRATCH: mscratch_r <= new_s;
                    ADDR_MEPC:     mepc_r     <= new_s[31:2];
                    ADDR_MCAUSE:   mcause_r   <= new_s;
                    default:       ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // Counters: a CSR write to either half replaces that half and skips the increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            mcycle_r   <= 64'h0;
            minstret_r <= 64'h0;
        end else begin
            if (we_s && (bus.csr_addr == ADDR_MCYCLE)) begin
                mcycle_r <= {mcycle_r[63:32], new_s};
            end else if (we_s && (bus.csr_addr == ADDR_MCYCLEH)) begin
                mcycle_r <= {new_s, mcycle_r[31:0]};
            end else begin
                mcycle_r <= mcycle_r + 64'd1;
            end
            if (we_s && (bus.csr_addr == ADDR_MINSTRET)) begin
                minstret_r <= {minstret_r[63:32], new_s};
            end else if (we_s && (bus.csr_addr == ADDR_MINSTRETH)) begin
                minstret_r <= {new_s, minstret_r[31:0]};
            end else if (bus.instr_retired) begin
                minstret_r <= minstret_r + 64'd1;
            end else begin
                minstret_r <= minstret_r;
            end
        end
    end
`endif
endmodule

// File: tb/tb_csr_register_file.sv
// Self-checking bench for csr_register_file: directed scenarios plus random traffic against a CSR model.
module tb_csr_register_file;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] HART      = 32'd3;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [11:0] RST_ADDR [6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14};
    localparam logic [31:0] RST_VAL  [6] = '{32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'd3};
    localparam logic [11:0] RND_ADDR [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
                                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                              12'hC02, 12'hC82, 12'h301, 12'h344};

    logic clk;
    logic rst;
    int   total;
    int   bad;

    csr_register_file_if bus();

    csr_register_file #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // model read: {implemented, value}
    function automatic logic [32:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_mstatus & 32'h88};
            12'h305: return {1'b1, m_mtvec & 32'hFFFF_FFFC};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc & 32'hFFFF_FFFC};
            12'h342: return {1'b1, m_mcause};
            12'hF14: return {1'b1, HART};
            12'hB00, 12'hC00: return CNT_EN ? {1'b1, m_cyc[31:0]}  : 33'd0;
            12'hB80, 12'hC80: return CNT_EN ? {1'b1, m_cyc[63:32]} : 33'd0;
            12'hB02, 12'hC02: return CNT_EN ? {1'b1, m_ins[31:0]}  : 33'd0;
            12'hB82, 12'hC82: return CNT_EN ? {1'b1, m_ins[63:32]} : 33'd0;
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic m_illegal();
        logic [32:0] r;
        r = mread(bus.csr_addr);
        return (bus.CSR_reg_rd | bus.CSR_reg_wr) &
               (!r[32] | (bus.CSR_reg_wr & (bus.csr_addr >= 12'hC00)));
    endfunction

    task automatic model_step();
        logic [32:0] r;
        logic [31:0] src, nv;
        logic [63:0] n_cyc, n_ins;
        logic        wr_ok;
        r = mread(bus.csr_addr);
        src = bus.RD1_RS1_sel ? {27'd0, bus.uimm} : bus.rs1_data;
        if (bus.CSR_wd_select == 2'd0) nv = src;
        else if (bus.CSR_wd_select == 2'd1) nv = r[31:0] | src;
        else if (bus.CSR_wd_select == 2'd2) nv = r[31:0] & ~src;
        else nv = r[31:0];
        if (!rst) begin
            m_mstatus = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_cyc = 0; m_ins = 0;
            return;
        end
        n_cyc = m_cyc + 64'd1;
        n_ins = m_ins + {63'd0, bus.instr_retired};
        wr_ok = bus.CSR_reg_wr && !m_illegal() && !bus.trap_valid;
        if (bus.trap_valid) begin
            m_mepc    = bus.trap_pc & 32'hFFFF_FFFC;
            m_mcause  = bus.trap_cause;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else begin
            if (bus.mret) m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            if (wr_ok) begin
                if (bus.csr_addr == 12'h300 && !bus.mret) m_mstatus = nv & 32'h88;
                if (bus.csr_addr == 12'h305) m_mtvec = nv;
                if (bus.csr_addr == 12'h340) m_mscratch = nv;
                if (bus.csr_addr == 12'h341) m_mepc = nv;
                if (bus.csr_addr == 12'h342) m_mcause = nv;
            end
        end
        if (wr_ok && CNT_EN) begin
            if (bus.csr_addr == 12'hB00) n_cyc = {m_cyc[63:32], nv};
            if (bus.csr_addr == 12'hB80) n_cyc = {nv, m_cyc[31:0]};
            if (bus.csr_addr == 12'hB02) n_ins = {m_ins[63:32], nv};
            if (bus.csr_addr == 12'hB82) n_ins = {nv, m_ins[31:0]};
        end
        m_cyc = n_cyc;
        m_ins = n_ins;
    endtask

    task automatic idle();
        bus.CSR_reg_rd = 1'b0; bus.CSR_reg_wr = 1'b0; bus.CSR_wd_select = 2'b11;
        bus.RD1_RS1_sel = 1'b0; bus.csr_addr = 12'h000; bus.rs1_data = 32'h0; bus.uimm = 5'h0;
        bus.instr_retired = 1'b0; bus.trap_valid = 1'b0; bus.trap_cause = 32'h0;
        bus.trap_pc = 32'h0; bus.mret = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sel, input logic imm,
                         input logic [11:0] a, input logic [31:0] d);
        bus.CSR_reg_rd = rd; bus.CSR_reg_wr = wr; bus.CSR_wd_select = sel;
        bus.RD1_RS1_sel = imm; bus.csr_addr = a; bus.rs1_data = d; bus.uimm = d[4:0];
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); tick(); tick(); rst = 1'b1; #1;
        total++;
        if (bus.csr_rdata !== 32'h0 || bus.illegal_csr !== 1'b0 || bus.mie_out !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got rdata=%h ill=%b mie=%b exp 0/0/0", bus.csr_rdata, bus.illegal_csr, bus.mie_out);
        end
        total++;
        if (bus.mtvec_out !== 32'h1000) begin bad++; $display("FAIL reset_mtvec_out got=%h exp=00001000", bus.mtvec_out); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 2'b11, 1'b0, RST_ADDR[i], 32'h0);
            total++;
            if (bus.csr_rdata !== RST_VAL[i] || bus.illegal_csr !== 1'b0) begin
                bad++; $display("FAIL reset_read[%h] got=%h ill=%b exp=%h", RST_ADDR[i], bus.csr_rdata, bus.illegal_csr, RST_VAL[i]);
            end
        end
        idle();
        repeat (5) tick();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hB00, 32'h0);
`ifdef CSR_COUNTERS_EN
        total++;
        if (bus.csr_rdata !== 32'd5 || bus.illegal_csr !== 1'b0) begin
            bad++; $display("FAIL mcycle_after_5 got=%h ill=%b exp=5", bus.csr_rdata, bus.illegal_csr);
        end
`else
        total++;
        if (bus.csr_rdata !== 32'd0 || bus.illegal_csr !== 1'b1) begin
            bad++; $display("FAIL nocnt_b00 got=%h ill=%b exp=0/1", bus.csr_rdata, bus.illegal_csr);
        end
`endif
        idle();
    endtask

    task automatic test_csr_ops();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 12'h340, 32'hDEADBEEF);
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL csrrw_old got=%h exp=0", bus.csr_rdata); end
        tick();
        drive(1'b1, 1'b1, 2'b01, 1'b1, 12'h340, 32'h5);
        total++; if (bus.csr_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL csrrs_old got=%h exp=deadbeef", bus.csr_rdata); end
        tick();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h340, 32'hF);
        total++; if (bus.csr_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL csrrc_old got=%h exp=deadbeef", bus.csr_rdata); end
        tick();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h340, 32'h0);
        total++; if (bus.csr_rdata !== 32'hDEADBEE0) begin bad++; $display("FAIL csrrc_new got=%h exp=deadbee0", bus.csr_rdata); end
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'h305, 32'h12345677);
        tick();
        total++; if (bus.mtvec_out !== 32'h12345674) begin bad++; $display("FAIL mtvec_align got=%h exp=12345674", bus.mtvec_out); end
        drive(1'b1, 1'b1, 2'b00, 1'b0, 12'hF14, 32'h55);
        total++; if (bus.illegal_csr !== 1'b1) begin bad++; $display("FAIL mhartid_wr_illegal got=%b exp=1", bus.illegal_csr); end
        tick();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hF14, 32'h0);
        total++; if (bus.csr_rdata !== HART || bus.illegal_csr !== 1'b0) begin bad++; $display("FAIL mhartid_rd got=%h ill=%b exp=3", bus.csr_rdata, bus.illegal_csr); end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 12'h7C0, 32'h0);
        total++; if (bus.illegal_csr !== 1'b0) begin bad++; $display("FAIL unimpl_noaccess got=%b exp=0", bus.illegal_csr); end
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'h7C0, 32'h0);
        total++; if (bus.illegal_csr !== 1'b1) begin bad++; $display("FAIL unimpl_wr got=%b exp=1", bus.illegal_csr); end
        idle();
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'hB00, 32'hFFFFFFFF); tick();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'hB80, 32'h0); tick();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hB00, 32'h0);
        total++; if (bus.csr_rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL mcycle_wr_lo got=%h exp=ffffffff", bus.csr_rdata); end
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hB80, 32'h0);
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL mcycle_wr_hi got=%h exp=0", bus.csr_rdata); end
        idle(); tick();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hB00, 32'h0);
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL mcycle_carry_lo got=%h exp=0", bus.csr_rdata); end
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hC80, 32'h0);
        total++; if (bus.csr_rdata !== 32'h1) begin bad++; $display("FAIL mcycle_carry_hi got=%h exp=1", bus.csr_rdata); end
        drive(1'b1, 1'b1, 2'b00, 1'b0, 12'hC00, 32'h1234);
        total++; if (bus.illegal_csr !== 1'b1) begin bad++; $display("FAIL cycle_wr_illegal got=%b exp=1", bus.illegal_csr); end
        tick();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hC00, 32'h0);
        total++; if (bus.csr_rdata !== 32'h1) begin bad++; $display("FAIL cycle_wr_ignored got=%h exp=1", bus.csr_rdata); end
`else
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'hB80, 32'h0);
        total++; if (bus.illegal_csr !== 1'b1) begin bad++; $display("FAIL nocnt_b80_wr got=%b exp=1", bus.illegal_csr); end
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hC02, 32'h0);
        total++; if (bus.illegal_csr !== 1'b1 || bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL nocnt_c02_rd got=%h ill=%b exp=0/1", bus.csr_rdata, bus.illegal_csr); end
`endif
        idle();
    endtask

    task automatic test_trap_mret();
        drive(1'b0, 1'b1, 2'b01, 1'b1, 12'h300, 32'h8); tick();
        total++; if (bus.mie_out !== 1'b1) begin bad++; $display("FAIL mie_set got=%b exp=1", bus.mie_out); end
        idle(); bus.trap_valid = 1'b1; bus.trap_pc = 32'h102; bus.trap_cause = 32'hB; #1; tick(); idle();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h342, 32'h0);
        total++; if (bus.csr_rdata !== 32'hB || bus.mepc_out !== 32'h100 || bus.mie_out !== 1'b0) begin
            bad++; $display("FAIL trap_entry got cause=%h mepc=%h mie=%b exp b/100/0", bus.csr_rdata, bus.mepc_out, bus.mie_out);
        end
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h300, 32'h0);
        total++; if (bus.csr_rdata !== 32'h80) begin bad++; $display("FAIL trap_mstatus got=%h exp=80", bus.csr_rdata); end
        idle(); bus.mret = 1'b1; #1; tick(); idle();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h300, 32'h0);
        total++; if (bus.csr_rdata !== 32'h88 || bus.mie_out !== 1'b1) begin bad++; $display("FAIL mret got=%h mie=%b exp=88/1", bus.csr_rdata, bus.mie_out); end
        drive(1'b0, 1'b1, 2'b10, 1'b1, 12'h300, 32'h8); tick();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'h300, 32'h0); bus.mret = 1'b1; #1; tick(); idle();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h300, 32'h0);
        total++; if (bus.csr_rdata !== 32'h88) begin bad++; $display("FAIL mret_beats_wr got=%h exp=88", bus.csr_rdata); end
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'h340, 32'hA5A5A5A5); bus.mret = 1'b1; #1; tick(); idle();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h340, 32'h0);
        total++; if (bus.csr_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL mret_with_wr got=%h exp=a5a5a5a5", bus.csr_rdata); end
        idle();
    endtask

    task automatic test_trap_vs_write();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'h340, 32'h1234);
        bus.trap_valid = 1'b1; bus.trap_pc = 32'h2003; bus.trap_cause = 32'h80000007; #1;
        tick(); idle();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h340, 32'h0);
        total++; if (bus.csr_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL trap_blocks_wr got=%h exp=a5a5a5a5", bus.csr_rdata); end
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h342, 32'h0);
        total++; if (bus.csr_rdata !== 32'h80000007 || bus.mepc_out !== 32'h2000 || bus.mie_out !== 1'b0) begin
            bad++; $display("FAIL trap_with_wr got cause=%h mepc=%h mie=%b exp 80000007/2000/0", bus.csr_rdata, bus.mepc_out, bus.mie_out);
        end
        idle();
    endtask

    task automatic test_reset_mid();
`ifdef CSR_COUNTERS_EN
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'hB02, 32'd7); tick();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hB02, 32'h0);
        total++; if (bus.csr_rdata !== 32'd7) begin bad++; $display("FAIL minstret_wr got=%h exp=7", bus.csr_rdata); end
`endif
        drive(1'b0, 1'b1, 2'b00, 1'b0, 12'h340, 32'h55);
        bus.trap_valid = 1'b1; bus.trap_pc = 32'h40; bus.instr_retired = 1'b1; rst = 1'b0; #1;
        tick(); rst = 1'b1; idle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 2'b11, 1'b0, RST_ADDR[i], 32'h0);
            total++;
            if (bus.csr_rdata !== RST_VAL[i]) begin bad++; $display("FAIL midreset_read[%h] got=%h exp=%h", RST_ADDR[i], bus.csr_rdata, RST_VAL[i]); end
        end
`ifdef CSR_COUNTERS_EN
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'hB02, 32'h0);
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL midreset_minstret got=%h exp=0", bus.csr_rdata); end
`endif
        idle();
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        logic        exp_ill;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            bus.instr_retired = $urandom_range(0, 1) == 1;
            bus.trap_valid = $urandom_range(0, 15) == 0;
            bus.trap_pc = $urandom; bus.trap_cause = $urandom;
            bus.mret = $urandom_range(0, 7) == 0;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? 12'($urandom) : RND_ADDR[$urandom_range(0, 15)], $urandom);
            exp_ill = m_illegal();
            exp_rd = bus.CSR_reg_rd ? mread(bus.csr_addr) : 32'h0;
            total++;
            if (bus.csr_rdata !== exp_rd || bus.illegal_csr !== exp_ill) begin
                bad++; $display("FAIL rnd_read[%0d] addr=%h got=%h/%b exp=%h/%b", n, bus.csr_addr, bus.csr_rdata, bus.illegal_csr, exp_rd, exp_ill);
            end
            total++;
            if (bus.mtvec_out !== (m_mtvec & 32'hFFFF_FFFC) || bus.mepc_out !== (m_mepc & 32'hFFFF_FFFC) || bus.mie_out !== m_mstatus[3]) begin
                bad++; $display("FAIL rnd_outs[%0d] got mtvec=%h mepc=%h mie=%b exp %h/%h/%b", n, bus.mtvec_out, bus.mepc_out, bus.mie_out,
                                m_mtvec & 32'hFFFF_FFFC, m_mepc & 32'hFFFF_FFFC, m_mstatus[3]);
            end
            tick();
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        total = 0; bad = 0;
        m_mstatus = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
        rst = 1'b0;
        idle();
        test_reset();
        test_csr_ops();
        test_counters();
        test_trap_mret();
        test_trap_vs_write();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
